// File: rtl/z80_clk_reset_gen.sv
// Z80 timing front end: debounces the reset button, divides eclk into the Z80 pad
// clock with one-cycle edge strobes, and sequences the Z80 _reset pulse.
module z80_clk_reset_gen #(
    parameter int HALFCYCLE = 100,
    parameter int DEBOUNCE  = 65536,
    parameter int RST_DELAY = 1000,
    parameter int RST_LEN   = 1000
) (
    input  logic       eclk,
    input  logic       reset_b,
    input  logic       btn_raw,
    output logic       ereset,
    output logic       z80_clk,
    output logic       z80_reset_b,
    output logic       clk_rise,
    output logic       clk_fall,
    output logic [1:0] seq_state
);

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_DELAY  = 2'd1,
        S_ASSERT = 2'd2,
        S_RUN    = 2'd3
    } seq_t;

    localparam logic [31:0] DEB_LAST   = 32'(DEBOUNCE - 1);
    localparam logic [31:0] HALF_LAST  = 32'(HALFCYCLE - 1);
    localparam logic [31:0] DELAY_LAST = 32'(RST_DELAY - 1);
    localparam logic [31:0] LEN_LAST   = 32'(RST_LEN - 1);

    generate
        if (HALFCYCLE < 2) begin : g_bad_half
            $error("HALFCYCLE must be >= 2");
        end
        if (DEBOUNCE < 1 || RST_DELAY < 1 || RST_LEN < 1) begin : g_bad_count
            $error("DEBOUNCE, RST_DELAY and RST_LEN must be >= 1");
        end
    endgenerate

    logic [1:0]  sync_q,   sync_d;
    logic        ereset_q, ereset_d;
    logic [31:0] dcnt_q,   dcnt_d;
    seq_t        state_q,  state_d;
    logic [31:0] scnt_q,   scnt_d;
    logic [31:0] div_q,    div_d;
    logic        zclk_q,   zclk_d;
    logic        zrst_q,   zrst_d;
    logic        rise_q,   rise_d;
    logic        fall_q,   fall_d;
    logic        btn_s;

    assign btn_s = sync_q[1];

    always_ff @(posedge eclk) begin
        if (!reset_b) begin
            sync_q   <= 2'b00;
            ereset_q <= 1'b0;
            dcnt_q   <= 32'd0;
            state_q  <= S_DELAY;
            scnt_q   <= 32'd0;
            div_q    <= 32'd0;
            zclk_q   <= 1'b0;
            zrst_q   <= 1'b1;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            ereset_q <= ereset_d;
            dcnt_q   <= dcnt_d;
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            div_q    <= div_d;
            zclk_q   <= zclk_d;
            zrst_q   <= zrst_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    always_comb begin
        sync_d   = {sync_q[0], btn_raw};
        ereset_d = ereset_q;
        dcnt_d   = 32'd0;
        state_d  = state_q;
        scnt_d   = scnt_q;
        div_d    = 32'd0;
        zclk_d   = 1'b0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;

        // The run counter restarts whenever the synchronised level agrees with ereset.
        if (btn_s != ereset_q) begin
            if (dcnt_q == DEB_LAST) begin
                ereset_d = btn_s;
            end else begin
                dcnt_d = dcnt_q + 32'd1;
            end
        end

        case (state_q)
            S_HOLD: begin
                state_d = S_DELAY;
                scnt_d  = 32'd0;
            end
            S_DELAY: begin
                if (scnt_q == DELAY_LAST) begin
                    state_d = S_ASSERT;
                    scnt_d  = 32'd0;
                end else begin
                    scnt_d = scnt_q + 32'd1;
                end
            end
            S_ASSERT: begin
                if (scnt_q == LEN_LAST) begin
                    state_d = S_RUN;
                    scnt_d  = 32'd0;
                end else begin
                    scnt_d = scnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        if (ereset_q) begin
            state_d = S_HOLD;
            scnt_d  = 32'd0;
        end

        // Output flop carries the level for the state being entered, so it never glitches.
        zrst_d = (state_d == S_DELAY) || (state_d == S_RUN);

        // Divider is frozen at zero while in HOLD and on the edge that enters it,
        // so leaving HOLD behaves exactly like leaving reset.
        if (state_q != S_HOLD && state_d != S_HOLD) begin
            zclk_d = zclk_q;
            if (div_q == HALF_LAST) begin
                zclk_d = ~zclk_q;
                rise_d = ~zclk_q;
                fall_d = zclk_q;
            end else begin
                div_d = div_q + 32'd1;
            end
        end
    end

    assign ereset      = ereset_q;
    assign z80_clk     = zclk_q;
    assign z80_reset_b = zrst_q;
    assign clk_rise    = rise_q;
    assign clk_fall    = fall_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_z80_clk_reset_gen.sv
// Bench for z80_clk_reset_gen: a time-based reference model (elapsed cycles since the
// sequence started, plus a queue-based debouncer) is compared against the DUT every cycle.
module tb_z80_clk_reset_gen;

    localparam int HC  = 4;
    localparam int DEB = 8;
    localparam int RD  = 20;
    localparam int RL  = 40;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic       btn_raw = 1'b0;
    logic       ereset, z80_clk, z80_reset_b, clk_rise, clk_fall;
    logic [1:0] seq_state;
    logic [6:0] dut_vec;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int cyc     = 0;
    int m_start = 0;
    bit m_hold  = 0;
    bit m_s1    = 0;
    bit m_s2    = 0;
    bit m_ereset = 0;
    bit evq[$];

    z80_clk_reset_gen #(
        .HALFCYCLE(HC), .DEBOUNCE(DEB), .RST_DELAY(RD), .RST_LEN(RL)
    ) dut (
        .eclk       (clk),
        .reset_b    (reset_b),
        .btn_raw    (btn_raw),
        .ereset     (ereset),
        .z80_clk    (z80_clk),
        .z80_reset_b(z80_reset_b),
        .clk_rise   (clk_rise),
        .clk_fall   (clk_fall),
        .seq_state  (seq_state)
    );

    always #5 clk = ~clk;

    assign dut_vec = {ereset, z80_clk, z80_reset_b, clk_rise, clk_fall, seq_state};

    // Advance one eclk edge, then update the model with the inputs seen at that edge.
    task automatic tick();
        bit old_e;
        @(posedge clk);
        #1;
        cyc++;
        if (!reset_b) begin
            m_s1 = 0; m_s2 = 0; m_ereset = 0; evq.delete();
            m_hold = 0; m_start = cyc;
        end else begin
            old_e = m_ereset;
            // ereset flips once DEB consecutive synchronised samples disagree with it.
            if (m_s2 == m_ereset) begin
                evq.delete();
            end else begin
                evq.push_back(m_s2);
                if (evq.size() == DEB) begin
                    m_ereset = m_s2;
                    evq.delete();
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
            if (old_e) begin
                m_hold = 1;
            end else if (m_hold) begin
                m_hold  = 0;
                m_start = cyc;
            end
        end
    endtask

    function automatic logic [6:0] model_out();
        int e;
        logic [1:0] st;
        logic rb, zc, ri, fa;
        if (m_hold) return {m_ereset, 6'b000000};
        e  = cyc - m_start;
        st = (e < RD) ? 2'd1 : (e < RD + RL) ? 2'd2 : 2'd3;
        rb = !(e >= RD && e < RD + RL);
        zc = ((e / HC) % 2) == 1;
        ri = (e >= HC) && (e % (2 * HC) == HC);
        fa = (e >= 2 * HC) && (e % (2 * HC) == 0);
        return {m_ereset, zc, rb, ri, fa, st};
    endfunction

    task automatic test_reset();
        reset_b = 1'b0;
        btn_raw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== model_out())
                $display("FAIL reset_vec cyc=%0d got=%b exp=%b", cyc, dut_vec, model_out());
            else n_pass++;
        end
        n_checks++;
        if (dut_vec !== 7'b0_0_1_0_0_01)
            $display("FAIL reset_state got=%b exp=%b", dut_vec, 7'b0010001);
        else n_pass++;
        reset_b = 1'b1;
        $display("test_reset done at cyc %0d", cyc);
    endtask

    task automatic test_power_on_sequence();
        int lo_cnt = 0;
        int first_hi = -1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== model_out())
                $display("FAIL poweron_vec cyc=%0d got=%b exp=%b", cyc, dut_vec, model_out());
            else n_pass++;
            if (!z80_reset_b) lo_cnt++;
            if (z80_clk && first_hi < 0) first_hi = i;
        end
        n_checks++;
        if (lo_cnt != RL) $display("FAIL poweron_low_len got=%0d exp=%0d", lo_cnt, RL);
        else n_pass++;
        n_checks++;
        if (first_hi != HC) $display("FAIL poweron_first_rise got=%0d exp=%0d", first_hi, HC);
        else n_pass++;
        $display("test_power_on_sequence done at cyc %0d", cyc);
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 0) btn_raw = ~btn_raw;
            tick();
            n_checks++;
            if (dut_vec !== model_out())
                $display("FAIL glitch_vec cyc=%0d got=%b exp=%b", cyc, dut_vec, model_out());
            else n_pass++;
        end
        btn_raw = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (ereset !== 1'b0 || seq_state !== 2'd3)
            $display("FAIL glitch_end got=%b/%0d exp=0/3", ereset, seq_state);
        else n_pass++;
        $display("test_glitch done at cyc %0d", cyc);
    endtask

    task automatic test_button_press();
        bit seen = 0;
        int lat = -1;
        btn_raw = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i == 7) btn_raw = 1'b0;
            tick();
            if (ereset) seen = 1;
            n_checks++;
            if (dut_vec !== model_out())
                $display("FAIL short_press_vec cyc=%0d got=%b exp=%b", cyc, dut_vec, model_out());
            else n_pass++;
        end
        n_checks++;
        if (seen) $display("FAIL short_press_ignored got=1 exp=0");
        else n_pass++;
        btn_raw = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (ereset && lat < 0) lat = i;
            n_checks++;
            if (dut_vec !== model_out())
                $display("FAIL press_vec cyc=%0d got=%b exp=%b", cyc, dut_vec, model_out());
            else n_pass++;
            if (i == lat + 1 && lat > 0) begin
                n_checks++;
                if (seq_state !== 2'd0 || z80_clk !== 1'b0 || z80_reset_b !== 1'b0)
                    $display("FAIL press_hold got=%0d/%b/%b exp=0/0/0", seq_state, z80_clk, z80_reset_b);
                else n_pass++;
            end
        end
        n_checks++;
        if (lat != DEB + 2) $display("FAIL press_latency got=%0d exp=%0d", lat, DEB + 2);
        else n_pass++;
        $display("test_button_press done at cyc %0d", cyc);
    endtask

    task automatic test_button_release();
        int lat = -1;
        int hi_cnt = 0;
        int lo_cnt = 0;
        btn_raw = 1'b0;
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            tick();
            if (!ereset) lat = i;
            n_checks++;
            if (dut_vec !== model_out())
                $display("FAIL release_vec cyc=%0d got=%b exp=%b", cyc, dut_vec, model_out());
            else n_pass++;
        end
        n_checks++;
        if (lat != DEB + 2) $display("FAIL release_latency got=%0d exp=%0d", lat, DEB + 2);
        else n_pass++;
        for (int i = 0; i < 81; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== model_out())
                $display("FAIL resequence_vec cyc=%0d got=%b exp=%b", cyc, dut_vec, model_out());
            else n_pass++;
            if (seq_state != 2'd0 && lo_cnt == 0 && z80_reset_b) hi_cnt++;
            if (!z80_reset_b && seq_state != 2'd0) lo_cnt++;
        end
        n_checks++;
        if (hi_cnt != RD || lo_cnt != RL)
            $display("FAIL resequence_len got=%0d/%0d exp=%0d/%0d", hi_cnt, lo_cnt, RD, RL);
        else n_pass++;
        $display("test_button_release done at cyc %0d", cyc);
    endtask

    task automatic test_run_strobes();
        int n_rise = 0, n_fall = 0, n_both = 0, n_bad = 0;
        logic prev_clk;
        prev_clk = z80_clk;
        for (int i = 0; i < 200; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== model_out())
                $display("FAIL strobe_vec cyc=%0d got=%b exp=%b", cyc, dut_vec, model_out());
            else n_pass++;
            if (clk_rise) n_rise++;
            if (clk_fall) n_fall++;
            if (clk_rise && clk_fall) n_both++;
            if (clk_rise !== (z80_clk && !prev_clk)) n_bad++;
            if (clk_fall !== (!z80_clk && prev_clk)) n_bad++;
            prev_clk = z80_clk;
        end
        n_checks++;
        if (n_rise != 25 || n_fall != 25 || n_both != 0 || n_bad != 0)
            $display("FAIL strobe_counts got=%0d/%0d/%0d/%0d exp=25/25/0/0", n_rise, n_fall, n_both, n_bad);
        else n_pass++;
        $display("test_run_strobes done at cyc %0d", cyc);
    endtask

    task automatic test_reset_mid_assert();
        int lo_cnt = 0;
        reset_b = 1'b0;
        tick();
        reset_b = 1'b1;
        for (int i = 0; i < 100 && (cyc - m_start) != RD + 17; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== model_out())
                $display("FAIL pre_pulse_vec cyc=%0d got=%b exp=%b", cyc, dut_vec, model_out());
            else n_pass++;
        end
        n_checks++;
        if (seq_state !== 2'd2 || z80_reset_b !== 1'b0)
            $display("FAIL pre_pulse_state got=%0d/%b exp=2/0", seq_state, z80_reset_b);
        else n_pass++;
        reset_b = 1'b0;
        tick();
        reset_b = 1'b1;
        n_checks++;
        if (z80_reset_b !== 1'b1 || z80_clk !== 1'b0 || seq_state !== 2'd1)
            $display("FAIL pulse_restart got=%b/%b/%0d exp=1/0/1", z80_reset_b, z80_clk, seq_state);
        else n_pass++;
        for (int i = 0; i < 70; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== model_out())
                $display("FAIL restart_vec cyc=%0d got=%b exp=%b", cyc, dut_vec, model_out());
            else n_pass++;
            if (!z80_reset_b) lo_cnt++;
        end
        n_checks++;
        if (lo_cnt != RL) $display("FAIL restart_low_len got=%0d exp=%0d", lo_cnt, RL);
        else n_pass++;
        $display("test_reset_mid_assert done at cyc %0d", cyc);
    endtask

    task automatic test_random();
        int hold_left = 0;
        int errs_before = n_checks - n_pass;
        for (int i = 0; i < 3000; i++) begin
            if (hold_left == 0) begin
                btn_raw   = $urandom_range(0, 1);
                hold_left = (($urandom_range(0, 3) == 0) ? $urandom_range(8, 40)
                                                         : $urandom_range(1, 9));
            end
            hold_left--;
            reset_b = ($urandom_range(0, 399) != 0);
            tick();
            n_checks++;
            if (dut_vec !== model_out())
                $display("FAIL random_vec cyc=%0d got=%b exp=%b", cyc, dut_vec, model_out());
            else n_pass++;
        end
        reset_b = 1'b1;
        btn_raw = 1'b0;
        $display("test_random done at cyc %0d, new errors %0d", cyc, (n_checks - n_pass) - errs_before);
    endtask

    initial begin
        test_reset();
        test_power_on_sequence();
        test_glitch();
        test_button_press();
        test_button_release();
        test_run_strobes();
        test_reset_mid_assert();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
